cache_mem_ctrl: RTL
===================

Name: cache_mem_ctrl

Overview:
- Backing-store controller directly downstream of the 8-bit, 16-bit-address cache.
- Serves cache line fills (reads) and line write-backs (writes) as fixed-length byte bursts after a programmable access latency.
- Holds the main-memory byte array internally.
- Uses separate address and data buses, with a simple req/busy/done handshake toward the cache miss logic.

Parameters:
- LINE_WORDS, 4: bytes per cache line; power of 2, range 2..16.
- LATENCY, 3: wait-state cycles before the first beat; range 0..15.
- CWF, 1: 1 = critical-word-first wrapping order; 0 = sequential from offset 0.
- MEM_AW, 10: memory array address width; array holds 2^MEM_AW bytes.

Ports:
- clock, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- req, input, 1: request strobe; sampled only in IDLE.
- rw, input, 1: 0 = line fill (read), 1 = write-back (write); latched with req.
- addr, input, 16: byte address; latched with req.
- wdata, input, 8: write-back byte for the current beat.
- busy, output, 1: request accepted and in progress.
- rvalid, output, 1: rdata valid this cycle (read bursts only).
- rdata, output, 8: fill byte for the current beat.
- wready, output, 1: wdata is consumed at the end of this cycle.
- done, output, 1: one-cycle pulse marking completion.
- beat, output, 4: word offset within the line being transferred.
- state, output, 3: FSM state, for waveforms; IDLE=0, WAIT=1, BURST=2, DONE=3.

Behaviour:
- Reset: on any edge with reset=1, the FSM goes to IDLE and busy, rvalid, rdata, wready, done, beat and state are all 0. Memory contents are untouched by reset.
- Reset mid-operation aborts immediately. No further array writes occur; bytes already written stay written.
- Line geometry:
  - Line base = addr with the low log2(LINE_WORDS) bits cleared.
  - Start offset = those low bits.
  - addr bits above MEM_AW are ignored, so addresses alias modulo 2^MEM_AW.
- Beat order for beat k (k = 0..LINE_WORDS-1):
  - CWF=1: offset = (start + k) mod LINE_WORDS, wrapping within the line; never crosses into the next line.
  - CWF=0: offset = k.
- IDLE:
  - On an edge with req=1, latch addr and rw, set busy=1, and go to WAIT (or directly to BURST if LATENCY=0).
  - req=0 leaves the FSM in IDLE.
- WAIT: lasts exactly LATENCY cycles, counted by an internal down-counter; then go to BURST.
- BURST: lasts exactly LINE_WORDS cycles, one beat per cycle. beat shows the offset of the current beat.
  - Read: rvalid=1 and rdata = mem[base + offset] during the same cycle. The implementation may prefetch to keep rdata registered.
  - Write: wready=1; mem[base + offset] <= wdata on the closing edge. Upstream holds the beat-k byte during the k-th BURST cycle.
  - After the last beat, go to DONE.
- DONE: one cycle with done=1, busy=0, rvalid=0, wready=0; then IDLE.
- Latency: with req sampled at edge E0, the first beat appears in cycle LATENCY+1, the last beat in cycle LATENCY+LINE_WORDS, and done in cycle LATENCY+LINE_WORDS+1.
- req while busy, or in the DONE cycle, is ignored and not queued. A req held high into IDLE is accepted on the next IDLE edge.
- rdata holds its last value when rvalid=0. beat returns to 0 in DONE and IDLE.
- Array reads and writes target only base + offset; no partial-line side effects.

Test Plan:
1. Reset values: assert reset for 2 edges mid-stream -> busy, rvalid, rdata, wready, done, beat, state all 0 on the next cycle.
2. Write-back at LATENCY=3, CWF=1, addr=0x0010, rw=1, wdata 0x11,0x22,0x33,0x44 on successive wready cycles -> wready high in cycles 4..7, beat 0,1,2,3, done pulse in cycle 8, busy high in cycles 1..7.
3. Critical-word-first fill: after scenario 2, req with rw=0, addr=0x0012 -> rvalid in cycles 4..7, beat 2,3,0,1, rdata 0x33,0x44,0x11,0x22.
   - Repeat with CWF=0 -> rdata 0x11,0x22,0x33,0x44.
4. Handshake edges:
   - req pulsed during WAIT and BURST -> ignored; exactly one done pulse.
   - req held high through DONE -> new request accepted on the first IDLE edge; busy rises the cycle after.
   - LATENCY=0 -> first beat in cycle 1.
5. Reset mid-burst: prefill line 0x0020 with 0xAA bytes, then start a write-back of 0x01..0x04 and assert reset after beat 1 -> read of 0x0020 returns 0x01,0x02,0xAA,0xAA.
6. Aliasing with MEM_AW=10: write line 0x0410 with 0x5A bytes, then read 0x0010 -> rdata 0x5A on all 4 beats.

Source files
------------

// File: rtl/cache_mem_ctrl.sv
// cache_mem_ctrl: backing-store controller for an 8-bit, 16-bit-address cache.
// It serves whole-line fills (reads) and write-backs (writes) as fixed-length
// byte bursts after a programmable number of wait states. The main-memory
// byte array lives inside this block.
//
// Ports:
//   clock, reset    - system clock, synchronous active-high reset
//   req, rw, addr   - request strobe (sampled in IDLE), 0=fill / 1=write-back, byte address
//   wdata           - write-back byte for the current beat
//   busy            - request accepted and in progress (WAIT or BURST)
//   rvalid, rdata   - fill byte valid / fill byte (rdata holds when rvalid=0)
//   wready          - wdata consumed at the end of this cycle
//   done            - one-cycle completion pulse
//   beat            - word offset within the line of the current beat
//   state           - FSM state for waveforms (IDLE=0, WAIT=1, BURST=2, DONE=3)
module cache_mem_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 3,
  parameter bit CWF        = 1'b1,
  parameter int MEM_AW     = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        rw,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        rvalid,
  output logic [7:0]  rdata,
  output logic        wready,
  output logic        done,
  output logic [3:0]  beat,
  output logic [2:0]  state
);

  localparam int              OW       = $clog2(LINE_WORDS);
  localparam logic [OW-1:0]   K_LAST   = OW'(LINE_WORDS - 1);
  localparam logic [3:0]      LAT_INIT = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_BURST = 3'd2,
    S_DONE  = 3'd3
  } state_t;

  state_t                state_reg, state_next;
  logic                  rw_reg, rw_next;
  logic [MEM_AW-OW-1:0]  line_reg, line_next;    // line index; offset bits kept apart
  logic [OW-1:0]         start_reg, start_next;  // critical-word offset
  logic [OW-1:0]         k_reg, k_next;          // beat counter within the burst
  logic [3:0]            wait_reg, wait_next;
  logic [7:0]            rdata_reg;

  logic [7:0]            mem [0:(1<<MEM_AW)-1];

  logic [OW-1:0]         cur_off, nxt_off;
  logic [MEM_AW-1:0]     cur_addr, nxt_addr;
  logic                  fetch;

  // Addresses alias modulo 2^MEM_AW; the upper address bits are dropped.
  if (MEM_AW < 16) begin : g_alias
    logic unused_hi;
    assign unused_hi = ^addr[15:MEM_AW];
  end

  // OW-bit addition wraps inside the line, giving critical-word-first order.
  assign cur_off  = CWF ? (start_reg + k_reg) : k_reg;
  assign nxt_off  = CWF ? (start_next + k_next) : k_next;
  assign cur_addr = {line_reg, cur_off};
  assign nxt_addr = {line_next, nxt_off};

  always_comb begin
    state_next = state_reg;
    rw_next    = rw_reg;
    line_next  = line_reg;
    start_next = start_reg;
    k_next     = k_reg;
    wait_next  = wait_reg;
    case (state_reg)
      S_IDLE: begin
        k_next = '0;
        if (req) begin
          rw_next    = rw;
          line_next  = addr[MEM_AW-1:OW];
          start_next = addr[OW-1:0];
          wait_next  = LAT_INIT;
          state_next = (LATENCY == 0) ? S_BURST : S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_reg == 4'd0) state_next = S_BURST;
        else                  wait_next  = wait_reg - 4'd1;
      end
      S_BURST: begin
        if (k_reg == K_LAST) state_next = S_DONE;
        else                 k_next     = k_reg + 1'b1;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Read data is fetched one cycle ahead, using the next-cycle beat address,
  // so rdata comes straight from a register during each BURST cycle.
  assign fetch = (state_next == S_BURST) && !rw_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= S_IDLE;
      rw_reg    <= 1'b0;
      line_reg  <= '0;
      start_reg <= '0;
      k_reg     <= '0;
      wait_reg  <= 4'd0;
      rdata_reg <= 8'd0;
    end else begin
      state_reg <= state_next;
      rw_reg    <= rw_next;
      line_reg  <= line_next;
      start_reg <= start_next;
      k_reg     <= k_next;
      wait_reg  <= wait_next;
      if (fetch) rdata_reg <= mem[nxt_addr];
    end
  end

  // Reset blocks the pending write so an aborted burst stops immediately.
  always_ff @(posedge clock) begin
    if (!reset && wready) mem[cur_addr] <= wdata;
  end

  assign busy   = (state_reg == S_WAIT) || (state_reg == S_BURST);
  assign rvalid = (state_reg == S_BURST) && !rw_reg;
  assign wready = (state_reg == S_BURST) && rw_reg;
  assign done   = (state_reg == S_DONE);
  assign beat   = (state_reg == S_BURST) ? 4'(cur_off) : 4'd0;
  assign rdata  = rdata_reg;
  assign state  = state_reg;

endmodule
